// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the data-memory port arbiter.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin arbitration).
package dmem_arb_pkg;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH_B = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of a word access: aligned and fully inside memory.
module dmem_req_check #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DEPTH_B = 64
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              err_o
);

    // Highest legal word start address (last word ends at DEPTH_B-1).
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_B - 4);

    always_comb begin
        err_o = (addr_i[1:0] != 2'b00) || (addr_i > MAX_ADDR);
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the cpu MEM stage and the debug/loader port.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin instead of cpu-first priority).
module dmem_port_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_ni,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_err_o,

    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_err_o,

    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    mem_req_t   req_q,   req_d;
    logic       err_q,   err_d;

    logic cpu_bad_c, dbg_bad_c;
    logic pick_cpu_c, pick_dbg_c;
    logic resp_c, load_ok_c;

    dmem_req_check #(.ADDR_W(ADDR_W), .DEPTH_B(DEPTH_B)) u_cpu_check (
        .addr_i (cpu_addr_i),
        .err_o  (cpu_bad_c)
    );

    dmem_req_check #(.ADDR_W(ADDR_W), .DEPTH_B(DEPTH_B)) u_dbg_check (
        .addr_i (dbg_addr_i),
        .err_o  (dbg_bad_c)
    );

    // Winner selection; owner_q doubles as the last-granted requester.
    always_comb begin
        pick_cpu_c = 1'b0;
        pick_dbg_c = 1'b0;
        if (state_q != ACCESS) begin
`ifdef DMEM_ARB_RR_EN
            pick_cpu_c = cpu_req_i && (!dbg_req_i || (owner_q == OWN_DBG));
`else
            pick_cpu_c = cpu_req_i;
`endif
            pick_dbg_c = dbg_req_i && !pick_cpu_c;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        req_d     = req_q;
        err_d     = err_q;
        cpu_gnt_o = pick_cpu_c;
        dbg_gnt_o = pick_dbg_c;

        if (pick_cpu_c) begin
            owner_d = OWN_CPU;
            req_d   = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i};
            err_d   = cpu_bad_c;
        end else if (pick_dbg_c) begin
            owner_d = OWN_DBG;
            req_d   = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};
            err_d   = dbg_bad_c;
        end

        unique case (state_q)
            IDLE:    state_d = (pick_cpu_c || pick_dbg_c) ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = (pick_cpu_c || pick_dbg_c) ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            owner_q <= OWN_DBG;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // Memory side: address/data follow the held payload, strobes only in ACCESS.
    always_comb begin
        mem_en_o    = (state_q == ACCESS) && !err_q;
        mem_wr_o    = (state_q == ACCESS) && !err_q && req_q.we;
        mem_addr_o  = req_q.addr;
        mem_wdata_o = req_q.wdata;
    end

    // Response side: only the owner sees rvalid/err/rdata.
    always_comb begin
        resp_c       = (state_q == RESP);
        load_ok_c    = !req_q.we && !err_q;
        cpu_rvalid_o = 1'b0;
        cpu_err_o    = 1'b0;
        cpu_rdata_o  = '0;
        dbg_rvalid_o = 1'b0;
        dbg_err_o    = 1'b0;
        dbg_rdata_o  = '0;
        if (resp_c && (owner_q == OWN_CPU)) begin
            cpu_rvalid_o = 1'b1;
            cpu_err_o    = err_q;
            cpu_rdata_o  = load_ok_c ? mem_rdata_i : '0;
        end
        if (resp_c && (owner_q == OWN_DBG)) begin
            dbg_rvalid_o = 1'b1;
            dbg_err_o    = err_q;
            dbg_rdata_o  = load_ok_c ? mem_rdata_i : '0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small registered memory attached.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [10:0] dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_wr;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int en_count = 0;
    logic preload = 1'b1;
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
        .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    // Registered memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hCAFE0000;
            mem[1] <= 32'h11223344;
        end else if (mem_en) begin
            if (mem_wr) mem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    always @(posedge clk) if (mem_en) en_count <= en_count + 1;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (3) tick();
        settle();
        checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_strobes: en=%b wr=%b exp 0", mem_en, mem_wr); end
        checks++; if (mem_addr !== 11'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: addr=%h wdata=%h exp 0", mem_addr, mem_wdata); end
        checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL reset_resp: crv=%b drv=%b cg=%b dg=%b exp 0", cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt); end
        tick();
        reset_ni = 1'b1;
        preload = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        int en0;
        en0 = en_count;
        tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 11'h08; cpu_wdata = 32'hDEADBEEF; settle();
        checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL st_gnt: cpu=%b dbg=%b exp 1/0", cpu_gnt, dbg_gnt); end
        tick(); cpu_req = 0; settle();
        checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 11'h08 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_access: en=%b wr=%b addr=%h wdata=%h", mem_en, mem_wr, mem_addr, mem_wdata); end
        tick(); cpu_req = 1; cpu_we = 0; cpu_wdata = 32'h0; settle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL st_resp: rv=%b err=%b rdata=%h exp 1/0/0", cpu_rvalid, cpu_err, cpu_rdata); end
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL ld_gnt_in_resp: got %b exp 1", cpu_gnt); end
        tick(); cpu_req = 0; settle();
        checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL ld_access: en=%b wr=%b rv=%b exp 1/0/0", mem_en, mem_wr, cpu_rvalid); end
        tick(); settle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_resp: rv=%b err=%b rdata=%h exp 1/0/deadbeef", cpu_rvalid, cpu_err, cpu_rdata); end
        checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin errors++; $display("FAIL ld_nonowner: rv=%b rdata=%h exp 0", dbg_rvalid, dbg_rdata); end
        checks++; if (en_count - en0 !== 2) begin errors++; $display("FAIL st_ld_en_pulses: got %0d exp 2", en_count - en0); end
        tick(); settle();
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL ld_rvalid_once: got %b exp 0", cpu_rvalid); end
    endtask

    task automatic test_misaligned();
        int en0;
        en0 = en_count;
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 11'h06; settle();
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL mis_gnt: got %b exp 1", cpu_gnt); end
        tick(); cpu_req = 0; settle();
        checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL mis_access: en=%b wr=%b exp 0", mem_en, mem_wr); end
        tick(); cpu_req = 1; cpu_addr = 11'h04; settle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL mis_resp: rv=%b err=%b rdata=%h exp 1/1/0", cpu_rvalid, cpu_err, cpu_rdata); end
        checks++; if (en_count - en0 !== 0) begin errors++; $display("FAIL mis_no_mem: pulses %0d exp 0", en_count - en0); end
        tick(); cpu_req = 0; settle();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 11'h04) begin errors++; $display("FAIL after_mis_access: en=%b addr=%h exp 1/004", mem_en, mem_addr); end
        tick(); settle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h11223344) begin errors++; $display("FAIL after_mis_resp: rv=%b err=%b rdata=%h exp 1/0/11223344", cpu_rvalid, cpu_err, cpu_rdata); end
        tick();
    endtask

    task automatic test_range();
        logic [10:0] addrs [3] = '{11'h03D, 11'h040, 11'h03C};
        logic        exp_e [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tick(); cpu_req = 1; cpu_we = 1; cpu_addr = addrs[i]; cpu_wdata = 32'hA5A50000 + 32'(i); settle();
            checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rng_gnt[%0d]: got %b exp 1", i, cpu_gnt); end
            tick(); cpu_req = 0; settle();
            checks++; if (mem_en !== !exp_e[i] || mem_wr !== !exp_e[i]) begin errors++; $display("FAIL rng_access[%0d]: en=%b wr=%b exp %b", i, mem_en, mem_wr, !exp_e[i]); end
            tick(); settle();
            checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== exp_e[i]) begin errors++; $display("FAIL rng_resp[%0d]: rv=%b err=%b exp 1/%b", i, cpu_rvalid, cpu_err, exp_e[i]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3] = '{32'hCAFE0000, 32'h11223344, 32'hDEADBEEF};
        int nrv;
        nrv = 0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k == 0) begin cpu_req = 1; cpu_we = 0; cpu_addr = 11'h00; end
            if (k == 1) cpu_addr = 11'h04;
            if (k == 3) cpu_addr = 11'h08;
            if (k == 5) cpu_req = 0;
            settle();
            checks++; if (cpu_gnt !== (k % 2 == 0 && k <= 4)) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b", k, cpu_gnt); end
            checks++; if (cpu_rvalid !== (k % 2 == 0 && k >= 2)) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b", k, cpu_rvalid); end
            if (k % 2 == 0 && k >= 2) begin
                checks++; if (cpu_rdata !== exp_d[k/2-1]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h exp %h", k, cpu_rdata, exp_d[k/2-1]); end
            end
            if (cpu_rvalid === 1'b1) nrv++;
        end
        checks++; if (nrv !== 3) begin errors++; $display("FAIL b2b_rvalid_count: got %0d exp 3", nrv); end
        tick();
    endtask

    task automatic test_arbitration();
        // 0 = cpu, 1 = dbg; order of grants with both requesting, cpu dropping after its k=4 grant.
`ifdef DMEM_ARB_RR_EN
        int exp_own [4] = '{0, 1, 0, 1};
`else
        int exp_own [4] = '{0, 0, 0, 1};
`endif
        logic [31:0] exp_d [2] = '{32'hCAFE0000, 32'h11223344};
        reset_ni = 0; tick(); reset_ni = 1; tick();
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k == 0) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 11'h00;
                dbg_req = 1; dbg_we = 0; dbg_addr = 11'h04;
            end
            if (k == 5) cpu_req = 0;
            if (k == 7) dbg_req = 0;
            settle();
            checks++;
            if (cpu_gnt !== (k % 2 == 0 && k <= 6 && exp_own[k/2] == 0) ||
                dbg_gnt !== (k % 2 == 0 && k <= 6 && exp_own[k/2] == 1)) begin
                errors++; $display("FAIL arb_gnt[%0d]: cpu=%b dbg=%b", k, cpu_gnt, dbg_gnt);
            end
            if (k % 2 == 0 && k >= 2) begin
                checks++;
                if (cpu_rvalid !== (exp_own[k/2-1] == 0) || dbg_rvalid !== (exp_own[k/2-1] == 1)) begin
                    errors++; $display("FAIL arb_rvalid[%0d]: cpu=%b dbg=%b", k, cpu_rvalid, dbg_rvalid);
                end
                checks++;
                if ((exp_own[k/2-1] == 0 && (cpu_rdata !== exp_d[0] || dbg_rdata !== 32'h0)) ||
                    (exp_own[k/2-1] == 1 && (dbg_rdata !== exp_d[1] || cpu_rdata !== 32'h0))) begin
                    errors++; $display("FAIL arb_rdata[%0d]: cpu=%h dbg=%h", k, cpu_rdata, dbg_rdata);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 11'h08; settle();
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b exp 1", cpu_gnt); end
        tick(); cpu_req = 0; settle();
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_access: en=%b exp 1", mem_en); end
        reset_ni = 0; #1;
        checks++; if (mem_en !== 1'b0 || mem_addr !== 11'h0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_immediate: en=%b addr=%h rv=%b exp 0", mem_en, mem_addr, cpu_rvalid); end
        tick(); tick(); reset_ni = 1; settle();
        checks++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_release: crv=%b drv=%b exp 0", cpu_rvalid, dbg_rvalid); end
        tick(); settle();
        checks++; if (cpu_rvalid !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rst_stale: rv=%b en=%b exp 0", cpu_rvalid, mem_en); end
        tick(); cpu_req = 1; cpu_addr = 11'h04; settle();
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rst_next_gnt: got %b exp 1", cpu_gnt); end
        tick(); cpu_req = 0; tick(); settle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h11223344) begin errors++; $display("FAIL rst_next_resp: rv=%b err=%b rdata=%h", cpu_rvalid, cpu_err, cpu_rdata); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_range();
        test_back_to_back();
        test_arbitration();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
